// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: depth, pointer/count widths and state encodings.
package fifo_pkg;

    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;

    typedef enum logic [2:0] {
        ST_INIT     = 3'b000,
        ST_WRITE    = 3'b001,
        ST_READ     = 3'b010,
        ST_WR_ERROR = 3'b011,
        ST_RD_ERROR = 3'b100
    } fifo_state_e;

    // Map a raw 3-bit code to a legal state; unused codes fall back to INIT.
    function automatic fifo_state_e decode_state(input logic [2:0] code);
        fifo_state_e s;
        case (code)
            3'b001:  s = ST_WRITE;
            3'b010:  s = ST_READ;
            3'b011:  s = ST_WR_ERROR;
            3'b100:  s = ST_RD_ERROR;
            default: s = ST_INIT;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around pointer register with synchronous reset and increment enable.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned W = PTR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    // Power-of-two depth makes natural overflow the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl_reg.sv
// FIFO control register: state, pointers, occupancy and register-file strobes.
module fifo_ctrl_reg
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH,
    localparam int unsigned ADDR_W  = $clog2(DEPTH),
    localparam int unsigned COUNT_W = ADDR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         next_state,
    output logic [2:0]         state,
    output logic [COUNT_W-1:0] data_count,
    output logic [ADDR_W-1:0]  head,
    output logic [ADDR_W-1:0]  tail,
    output logic               we,
    output logic               re,
    output logic [ADDR_W-1:0]  waddr,
    output logic [ADDR_W-1:0]  raddr,
    output logic               wr_ack,
    output logic               wr_err,
    output logic               rd_ack,
    output logic               rd_err,
    output logic               full,
    output logic               empty
);

    fifo_state_e state_q;
    fifo_state_e state_d;
    fifo_state_e req_state;
    logic        do_wr;
    logic        do_rd;
    logic        wr_err_d;
    logic        rd_err_d;

    // Status flags straight from the registered count.
    assign full  = (data_count == COUNT_W'(DEPTH));
    assign empty = (data_count == COUNT_W'(0));
    assign state = state_q;

    // Resolve the requested state against occupancy; overflow/underflow become errors.
    always_comb begin
        state_d   = ST_INIT;
        do_wr     = 1'b0;
        do_rd     = 1'b0;
        wr_err_d  = 1'b0;
        rd_err_d  = 1'b0;
        req_state = decode_state(next_state);
        case (req_state)
            ST_WRITE: begin
                if (full) begin
                    state_d  = ST_WR_ERROR;
                    wr_err_d = 1'b1;
                end else begin
                    state_d = ST_WRITE;
                    do_wr   = 1'b1;
                end
            end
            ST_READ: begin
                if (empty) begin
                    state_d  = ST_RD_ERROR;
                    rd_err_d = 1'b1;
                end else begin
                    state_d = ST_READ;
                    do_rd   = 1'b1;
                end
            end
            ST_WR_ERROR: begin
                state_d  = ST_WR_ERROR;
                wr_err_d = 1'b1;
            end
            ST_RD_ERROR: begin
                state_d  = ST_RD_ERROR;
                rd_err_d = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy count and one-cycle strobes/status; addresses hold between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_count <= '0;
            we         <= 1'b0;
            re         <= 1'b0;
            wr_ack     <= 1'b0;
            wr_err     <= 1'b0;
            rd_ack     <= 1'b0;
            rd_err     <= 1'b0;
            waddr      <= '0;
            raddr      <= '0;
        end else begin
            we     <= do_wr;
            wr_ack <= do_wr;
            re     <= do_rd;
            rd_ack <= do_rd;
            wr_err <= wr_err_d;
            rd_err <= rd_err_d;
            if (do_wr) begin
                waddr      <= tail;
                data_count <= data_count + COUNT_W'(1);
            end else if (do_rd) begin
                raddr      <= head;
                data_count <= data_count - COUNT_W'(1);
            end
        end
    end

    // Read pointer.
    fifo_ptr #(.W(ADDR_W)) u_head (
        .clk (clk),
        .rst (rst),
        .inc (do_rd),
        .ptr (head)
    );

    // Write pointer.
    fifo_ptr #(.W(ADDR_W)) u_tail (
        .clk (clk),
        .rst (rst),
        .inc (do_wr),
        .ptr (tail)
    );

endmodule

// File: tb/tb_fifo_ctrl_reg.sv
// Scoreboard bench for fifo_ctrl_reg: directed steps push expectations, a monitor checks.
module tb_fifo_ctrl_reg;

    localparam logic [2:0] NS_INIT = 3'b000;
    localparam logic [2:0] NS_WR   = 3'b001;
    localparam logic [2:0] NS_RD   = 3'b010;
    localparam logic [2:0] NS_WERR = 3'b011;
    localparam logic [2:0] NS_RERR = 3'b100;

    localparam int K_NONE = 0;
    localparam int K_WR   = 1;
    localparam int K_RD   = 2;
    localparam int K_WERR = 3;
    localparam int K_RERR = 4;
    localparam int K_RST  = 5;

    typedef struct {
        string      name;
        logic [2:0] st;
        logic [3:0] cnt;
        logic [2:0] head;
        logic [2:0] tail;
        logic [2:0] addr;
        int         kind;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [2:0] next_state;
    logic [2:0] state;
    logic [3:0] data_count;
    logic [2:0] head;
    logic [2:0] tail;
    logic       we;
    logic       re;
    logic [2:0] waddr;
    logic [2:0] raddr;
    logic       wr_ack;
    logic       wr_err;
    logic       rd_ack;
    logic       rd_err;
    logic       full;
    logic       empty;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;
    bit   stim_done;

    fifo_ctrl_reg dut (
        .clk        (clk),
        .rst        (rst),
        .next_state (next_state),
        .state      (state),
        .data_count (data_count),
        .head       (head),
        .tail       (tail),
        .we         (we),
        .re         (re),
        .waddr      (waddr),
        .raddr      (raddr),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err),
        .full       (full),
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus on the falling edge and queue its expected outcome.
    task automatic step(input string name, input logic r, input logic [2:0] ns,
                        input logic [2:0] st, input int kind, input int addr,
                        input int cnt, input int h, input int t);
        exp_t e;
        @(negedge clk);
        rst        = r;
        next_state = ns;
        e.name = name;
        e.st   = st;
        e.kind = kind;
        e.addr = 3'(addr);
        e.cnt  = 4'(cnt);
        e.head = 3'(h);
        e.tail = 3'(t);
        exp_q.push_back(e);
    endtask

    // Monitor: after each rising edge, pop one expectation and compare all outputs.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [2:0] act_addr;
            logic [5:0] exp_stb;
            logic [5:0] act_stb;
            logic [22:0] act_v;
            logic [22:0] exp_v;
            e = exp_q.pop_front();
            case (e.kind)
                K_WR:    begin exp_stb = 6'b101000; act_addr = waddr; end
                K_RD:    begin exp_stb = 6'b010010; act_addr = raddr; end
                K_WERR:  begin exp_stb = 6'b000100; act_addr = e.addr; end
                K_RERR:  begin exp_stb = 6'b000001; act_addr = e.addr; end
                K_RST:   begin exp_stb = 6'b000000; act_addr = waddr | raddr; end
                default: begin exp_stb = 6'b000000; act_addr = e.addr; end
            endcase
            act_stb = {we, re, wr_ack, wr_err, rd_ack, rd_err};
            act_v = {state, data_count, head, tail, act_stb, full, empty, act_addr};
            exp_v = {e.st, e.cnt, e.head, e.tail, exp_stb,
                     (e.cnt == 4'd8), (e.cnt == 4'd0), e.addr};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL %s: got st=%0d cnt=%0d h=%0d t=%0d stb=%b f=%b e=%b a=%0d, want st=%0d cnt=%0d h=%0d t=%0d stb=%b f=%b e=%b a=%0d",
                         e.name, state, data_count, head, tail, act_stb, full, empty, act_addr,
                         e.st, e.cnt, e.head, e.tail, exp_stb,
                         (e.cnt == 4'd8), (e.cnt == 4'd0), e.addr);
            end
        end
    end

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        stim_done  = 1'b0;
        rst        = 1'b1;
        next_state = NS_INIT;

        step("reset", 1'b1, NS_WR, NS_INIT, K_RST, 0, 0, 0, 0);

        for (int i = 0; i < 8; i++)
            step("fill_wr", 1'b0, NS_WR, NS_WR, K_WR, i, i + 1, 0, (i + 1) % 8);

        step("wr_when_full", 1'b0, NS_WR, NS_WERR, K_WERR, 0, 8, 0, 0);
        step("wr_err_direct", 1'b0, NS_WERR, NS_WERR, K_WERR, 0, 8, 0, 0);

        for (int i = 0; i < 8; i++)
            step("drain_rd", 1'b0, NS_RD, NS_RD, K_RD, i, 7 - i, (i + 1) % 8, 0);

        step("rd_when_empty", 1'b0, NS_RD, NS_RERR, K_RERR, 0, 0, 0, 0);
        step("rd_err_direct", 1'b0, NS_RERR, NS_RERR, K_RERR, 0, 0, 0, 0);

        for (int i = 0; i < 3; i++)
            step("pre_wr", 1'b0, NS_WR, NS_WR, K_WR, i, i + 1, 0, i + 1);

        for (int j = 0; j < 20; j++) begin
            if (j % 2 == 0)
                step("alt_wr", 1'b0, NS_WR, NS_WR, K_WR, (3 + j / 2) % 8, 4,
                     (j / 2) % 8, (4 + j / 2) % 8);
            else
                step("alt_rd", 1'b0, NS_RD, NS_RD, K_RD, (j / 2) % 8, 3,
                     (j / 2 + 1) % 8, (4 + j / 2) % 8);
        end

        step("to5_wr", 1'b0, NS_WR, NS_WR, K_WR, 5, 4, 2, 6);
        step("to5_wr", 1'b0, NS_WR, NS_WR, K_WR, 6, 5, 2, 7);
        step("rst_mid_wr", 1'b1, NS_WR, NS_INIT, K_RST, 0, 0, 0, 0);
        step("after_rst_idle", 1'b0, NS_INIT, NS_INIT, K_RST, 0, 0, 0, 0);

        for (int i = 0; i < 4; i++)
            step("to4_wr", 1'b0, NS_WR, NS_WR, K_WR, i, i + 1, 0, i + 1);

        step("illegal_110", 1'b0, 3'b110, NS_INIT, K_NONE, 0, 4, 0, 4);
        step("illegal_101", 1'b0, 3'b101, NS_INIT, K_NONE, 0, 4, 0, 4);
        step("illegal_111", 1'b0, 3'b111, NS_INIT, K_NONE, 0, 4, 0, 4);
        step("init_hold", 1'b0, NS_INIT, NS_INIT, K_NONE, 0, 4, 0, 4);
        step("rd_after_illegal", 1'b0, NS_RD, NS_RD, K_RD, 0, 3, 1, 4);

        repeat (3) @(negedge clk);
        stim_done = 1'b1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        if (!stim_done) begin
            $display("FAIL timeout: simulation did not finish, want completion");
            $fatal(1, "timeout");
        end
    end

endmodule

// File: doc/fifo_ctrl_reg.md
FIFO_CTRL_REG -- requirements
Module: fifo_ctrl_reg

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, FIFO entry count (power of two; pointer width = log2(DEPTH), count width = log2(DEPTH)+1).
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port next_state, input, 3, next FIFO state from the next-state logic.
REQ-005 The block SHALL have port state, output, 3, registered current FIFO state, fed back to the next-state logic.
REQ-006 The block SHALL have port data_count, output, 4, number of valid entries (0..8), fed back to the next-state logic.
REQ-007 The block SHALL have ports head and tail, output, 3 each, read pointer and write pointer.
REQ-008 The block SHALL have ports we and re, output, 1 each, one-cycle write/read strobes to the register file.
REQ-009 The block SHALL have ports waddr and raddr, output, 3 each, register-file addresses qualified by we/re.
REQ-010 The block SHALL have ports wr_ack, wr_err, rd_ack, rd_err, output, 1 each, registered handshake status.
REQ-011 The block SHALL have ports full and empty, output, 1 each, status flags.

Function
REQ-012 State encodings SHALL be INIT=000, WRITE=001, READ=010, WR_ERROR=011, RD_ERROR=100.
REQ-013 On every rising edge, state SHALL load next_state; encodings 101..111 SHALL load INIT.
REQ-014 WRITE with data_count<8: tail+1 (mod 8), data_count+1; next cycle we=1, waddr=pre-increment tail, wr_ack=1.
REQ-015 READ with data_count>0: head+1 (mod 8), data_count-1; next cycle re=1, raddr=pre-increment head, rd_ack=1.
REQ-016 WRITE with data_count==8 SHALL be handled as WR_ERROR.
REQ-017 READ with data_count==0 SHALL be handled as RD_ERROR.
REQ-018 WR_ERROR SHALL hold pointers and count; next cycle wr_err=1, we=0.
REQ-019 RD_ERROR SHALL hold pointers and count; next cycle rd_err=1, re=0.
REQ-020 INIT and illegal encodings SHALL hold pointers and count; all strobes and status bits SHALL be 0.
REQ-021 we, re, wr_ack, wr_err, rd_ack, rd_err SHALL be registered and SHALL be 0 unless set by the previous edge's case; at most one SHALL be active per cycle.
REQ-022 full SHALL be data_count==8 and empty SHALL be data_count==0, both combinational from the registered count.
REQ-023 Pointer wrap SHALL be 7->0 with no flag; data_count SHALL never leave 0..8.
REQ-024 Latency from next_state sampled to strobe/ack/err visible SHALL be one clock.

Reset
REQ-025 With rst=1 at a rising edge: state=INIT, head=0, tail=0, data_count=0, all strobes/status 0, waddr=raddr=0, empty=1, full=0.
REQ-026 Reset SHALL take priority over next_state, including mid-write or mid-read; no strobe SHALL be issued in the cycle after a reset edge.

Structure
REQ-027 State encodings, DEPTH, and pointer and count widths SHALL live in shared package fifo_pkg, which fifo_ns also uses.
REQ-028 One sub-module, fifo_ptr (wrap-around pointer register with sync reset and increment enable), SHALL be instantiated twice, for head and for tail.
REQ-029 Total RTL size SHALL be 120-400 lines.

Verification
REQ-030 Reset, then 8 consecutive WRITE -> we pulses with waddr 0..7, data_count 1..8, full=1 after the 8th; no wr_err.
REQ-031 From full, WRITE -> handled as WR_ERROR; wr_err=1, tail=0, data_count=8, we=0.
REQ-032 From full, 8 READ -> re pulses with raddr 0..7, empty=1 at end; a 9th READ -> rd_err=1, head=0, re=0.
REQ-033 Alternating WRITE/READ 20 times from count=3 -> pointers wrap 7->0 correctly; data_count alternates 4/3.
REQ-034 rst asserted during a WRITE burst at count=5 -> next cycle all outputs at reset values; we=0.
REQ-035 next_state=110 at count=4 -> state=INIT, all strobes/status 0, count/pointers unchanged.
